// File: rtl/mrsc_pkg.sv
// Shared types and constants for the MRSC scrubber and its codec pair.
package mrsc_pkg;

  localparam int unsigned MRSC_DATA_W = 16;
  localparam int unsigned MRSC_CODE_W = 32;

  // Decoder error_code encoding; both 1x codes are uncorrectable.
  typedef enum logic [1:0] {
    ERR_NONE = 2'b00,
    ERR_CORR = 2'b01,
    ERR_UNC  = 2'b10,
    ERR_UNC2 = 2'b11
  } mrsc_err_e;

  typedef enum logic [2:0] {
    StIdle,
    StRd,
    StWt,
    StChk,
    StEnc,
    StWr,
    StNxt
  } scrub_state_e;

endpackage

// File: rtl/scrub_sat_counter.sv
// Saturating event counter with synchronous clear; clear has priority over increment.
module scrub_sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_d, cnt_q;

  // Next count: clear, hold at all-ones, or step by one.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/mrsc_scrub_controller.sv
// Background scrubber: reads every word, checks it through the external MRSC decoder,
// writes back re-encoded data for correctable words and counts error events.
module mrsc_scrub_controller
  import mrsc_pkg::*;
#(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   abort,
  output logic                   busy,
  output logic                   done,
  output logic                   mem_req,
  output logic                   mem_we,
  output logic [ADDR_W-1:0]      mem_addr,
  output logic [MRSC_CODE_W-1:0] mem_wdata,
  input  logic                   mem_gnt,
  input  logic                   mem_rvalid,
  input  logic [MRSC_CODE_W-1:0] mem_rdata,
  output logic [MRSC_CODE_W-1:0] dec_word,
  input  logic [MRSC_DATA_W-1:0] dec_data,
  input  logic [1:0]             dec_err,
  output logic [MRSC_DATA_W-1:0] enc_data,
  input  logic [MRSC_CODE_W-1:0] enc_word,
  output logic [CNT_W-1:0]       corr_cnt,
  output logic [CNT_W-1:0]       uncorr_cnt,
  output logic [ADDR_W-1:0]      last_uncorr_addr,
  output logic                   irq_uncorr
);

  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);

  scrub_state_e           state_d, state_q;
  logic [ADDR_W-1:0]      addr_d, addr_q;
  logic [MRSC_CODE_W-1:0] dec_word_d, dec_word_q;
  logic [MRSC_DATA_W-1:0] enc_data_d, enc_data_q;
  logic [MRSC_CODE_W-1:0] wdata_d, wdata_q;
  logic [ADDR_W-1:0]      last_unc_d, last_unc_q;
  logic                   irq_d, irq_q;
  // Set when an abort leaves a read response in flight; that response must not be consumed.
  logic                   drop_d, drop_q;
  logic                   cnt_clr, corr_inc, unc_inc;

  // Next-state, datapath captures and event strobes.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    dec_word_d = dec_word_q;
    enc_data_d = enc_data_q;
    wdata_d    = wdata_q;
    last_unc_d = last_unc_q;
    irq_d      = irq_q;
    drop_d     = drop_q;
    cnt_clr    = 1'b0;
    corr_inc   = 1'b0;
    unc_inc    = 1'b0;
    done       = 1'b0;

    if (mem_rvalid) begin
      drop_d = 1'b0;
    end

    if (abort) begin
      state_d = StIdle;
      // A granted read whose data has not been consumed is still on its way back.
      if (state_q == StWt && !(mem_rvalid && !drop_q)) begin
        drop_d = 1'b1;
      end
      if (state_q == StRd && mem_gnt) begin
        drop_d = 1'b1;
      end
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_d = StRd;
            addr_d  = '0;
            irq_d   = 1'b0;
            cnt_clr = 1'b1;
          end
        end
        StRd: begin
          if (mem_gnt) begin
            state_d = StWt;
          end
        end
        StWt: begin
          if (mem_rvalid && !drop_q) begin
            dec_word_d = mem_rdata;
            state_d    = StChk;
          end
        end
        StChk: begin
          unique case (mrsc_err_e'(dec_err))
            ERR_NONE: state_d = StNxt;
            ERR_CORR: begin
              enc_data_d = dec_data;
              corr_inc   = 1'b1;
              state_d    = StEnc;
            end
            default: begin
              unc_inc    = 1'b1;
              last_unc_d = addr_q;
              irq_d      = 1'b1;
              state_d    = StNxt;
            end
          endcase
        end
        StEnc: begin
          wdata_d = enc_word;
          state_d = StWr;
        end
        StWr: begin
          if (mem_gnt) begin
            state_d = StNxt;
          end
        end
        StNxt: begin
          if (addr_q == LastAddr) begin
            done    = 1'b1;
            state_d = StIdle;
          end else begin
            addr_d  = addr_q + ADDR_W'(1);
            state_d = StRd;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      dec_word_q <= '0;
      enc_data_q <= '0;
      wdata_q    <= '0;
      last_unc_q <= '0;
      irq_q      <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      dec_word_q <= dec_word_d;
      enc_data_q <= enc_data_d;
      wdata_q    <= wdata_d;
      last_unc_q <= last_unc_d;
      irq_q      <= irq_d;
      drop_q     <= drop_d;
    end
  end

  scrub_sat_counter #(
    .CNT_W (CNT_W)
  ) u_corr_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .inc   (corr_inc),
    .cnt   (corr_cnt)
  );

  scrub_sat_counter #(
    .CNT_W (CNT_W)
  ) u_uncorr_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .inc   (unc_inc),
    .cnt   (uncorr_cnt)
  );

  assign busy             = (state_q != StIdle);
  assign mem_req          = (state_q == StRd) || (state_q == StWr);
  assign mem_we           = (state_q == StWr);
  assign mem_addr         = addr_q;
  assign mem_wdata        = wdata_q;
  assign dec_word         = dec_word_q;
  assign enc_data         = enc_data_q;
  assign last_uncorr_addr = last_unc_q;
  assign irq_uncorr       = irq_q;

endmodule

// File: tb/tb_mrsc_scrub_controller.sv
// Directed bench: a shared memory responder with programmable grant delay and read latency,
// a table-driven stand-in for the MRSC codec, and two controller instances.
module tb_mrsc_scrub_controller;

  localparam logic [31:0] CLEAN  = 32'h80FA4B80;
  localparam logic [31:0] CORR   = 32'hB0FA4B80;
  localparam logic [31:0] BAD    = 32'hB0FA4B81;
  localparam logic [15:0] DATA_V = 16'h4B80;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic sel = 1'b0;

  // Controller A: DEPTH 4, 16b counters.
  logic        busy_a, done_a, req_a, we_a;
  logic [7:0]  addr_a, last_a;
  logic [31:0] wdata_a, dword_a, eword_a;
  logic [15:0] ddata_a, edata_a, corr_a, unc_a;
  logic [1:0]  derr_a;
  logic        irq_a, gnt_a, rvalid_a;

  // Controller B: DEPTH 8, 2b counters.
  logic        busy_b, done_b, req_b, we_b;
  logic [7:0]  addr_b, last_b;
  logic [31:0] wdata_b, dword_b, eword_b;
  logic [15:0] ddata_b, edata_b;
  logic [1:0]  corr_b, unc_b;
  logic [1:0]  derr_b;
  logic        irq_b, gnt_b, rvalid_b;

  // Responder state.
  logic        gnt = 1'b0, rvalid = 1'b0;
  logic [31:0] rdata = '0;
  logic [31:0] mem [0:255];
  int          gdly = 0, rlat = 2, wait_cnt = 0, cyc = 0;
  int          rd_cnt = 0, wr_cnt = 0, done_cnt = 0, stab_err = 0;
  logic [7:0]  wr_addr = '0;
  logic [31:0] wr_data = '0;
  int          rq_due [$];
  logic [31:0] rq_dat [$];
  logic        p_req = 1'b0, p_gnt = 1'b0;
  logic [40:0] p_bus = '0;

  int n_vec = 0, n_err = 0;

  always #5 clk = ~clk;

  function automatic logic [17:0] codec_dec(input logic [31:0] w);
    if (w == CLEAN) return {2'b00, DATA_V};
    if (w == CORR)  return {2'b01, DATA_V};
    if (w == BAD)   return {2'b10, 16'h0000};
    return {2'b11, 16'h0000};
  endfunction

  assign {derr_a, ddata_a} = codec_dec(dword_a);
  assign {derr_b, ddata_b} = codec_dec(dword_b);
  assign eword_a = (edata_a == DATA_V) ? CLEAN : 32'hDEADBEEF;
  assign eword_b = (edata_b == DATA_V) ? CLEAN : 32'hDEADBEEF;

  logic        m_req, m_we;
  logic [7:0]  m_addr;
  logic [31:0] m_wdata;
  assign m_req    = sel ? req_b : req_a;
  assign m_we     = sel ? we_b : we_a;
  assign m_addr   = sel ? addr_b : addr_a;
  assign m_wdata  = sel ? wdata_b : wdata_a;
  assign gnt_a    = gnt & ~sel;
  assign gnt_b    = gnt & sel;
  assign rvalid_a = rvalid & ~sel;
  assign rvalid_b = rvalid & sel;

  mrsc_scrub_controller #(.ADDR_W(8), .DEPTH(4), .CNT_W(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start & ~sel), .abort(abort & ~sel),
    .busy(busy_a), .done(done_a), .mem_req(req_a), .mem_we(we_a), .mem_addr(addr_a),
    .mem_wdata(wdata_a), .mem_gnt(gnt_a), .mem_rvalid(rvalid_a), .mem_rdata(rdata),
    .dec_word(dword_a), .dec_data(ddata_a), .dec_err(derr_a), .enc_data(edata_a),
    .enc_word(eword_a), .corr_cnt(corr_a), .uncorr_cnt(unc_a), .last_uncorr_addr(last_a),
    .irq_uncorr(irq_a)
  );

  mrsc_scrub_controller #(.ADDR_W(8), .DEPTH(8), .CNT_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start & sel), .abort(abort & sel),
    .busy(busy_b), .done(done_b), .mem_req(req_b), .mem_we(we_b), .mem_addr(addr_b),
    .mem_wdata(wdata_b), .mem_gnt(gnt_b), .mem_rvalid(rvalid_b), .mem_rdata(rdata),
    .dec_word(dword_b), .dec_data(ddata_b), .dec_err(derr_b), .enc_data(edata_b),
    .enc_word(eword_b), .corr_cnt(corr_b), .uncorr_cnt(unc_b), .last_uncorr_addr(last_b),
    .irq_uncorr(irq_b)
  );

  // Memory responder and event monitor, evaluated mid-cycle so values hold across the edge.
  always @(negedge clk) begin
    cyc++;
    rvalid = 1'b0;
    if (!rst_n) begin
      rq_due.delete();
      rq_dat.delete();
    end else if (rq_due.size() > 0 && rq_due[0] <= cyc) begin
      rvalid = 1'b1;
      rdata  = rq_dat[0];
      void'(rq_due.pop_front());
      void'(rq_dat.pop_front());
    end
    gnt = m_req && (wait_cnt >= gdly);
    if (m_req && !gnt) wait_cnt++;
    else wait_cnt = 0;
    if (gnt) begin
      if (m_we) begin
        wr_cnt++;
        wr_addr = m_addr;
        wr_data = m_wdata;
        mem[m_addr] = m_wdata;
      end else begin
        rd_cnt++;
        rq_due.push_back(cyc + rlat);
        rq_dat.push_back(mem[m_addr]);
      end
    end
    if (sel ? done_b : done_a) done_cnt++;
    if (p_req && !p_gnt && m_req && ({m_we, m_addr, m_wdata} != p_bus)) stab_err++;
    p_req = m_req;
    p_gnt = gnt;
    p_bus = {m_we, m_addr, m_wdata};
  end

  task automatic check_eq(input string tag, input logic [159:0] got, input logic [159:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_stats();
    rd_cnt = 0;
    wr_cnt = 0;
    done_cnt = 0;
    stab_err = 0;
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  // Start a sweep on the selected controller, re-pulse start mid-sweep, wait for idle.
  task automatic run_sweep(input logic s);
    bit ok = 1'b0;
    sel = s;
    clear_stats();
    pulse_start();
    repeat (3) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk); #1;
      if (!(s ? busy_b : busy_a)) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check_eq("sweep_timeout", 1, 0);
  endtask

  initial begin
    bit found;
    for (int i = 0; i < 256; i++) mem[i] = CLEAN;
    repeat (2) @(negedge clk);
    check_eq("reset_a", {busy_a, done_a, req_a, we_a, addr_a, wdata_a, dword_a, edata_a,
                         corr_a, unc_a, last_a, irq_a}, '0);
    check_eq("reset_b", {busy_b, done_b, req_b, we_b, addr_b, wdata_b, dword_b, edata_b,
                         corr_b, unc_b, last_b, irq_b}, '0);
    @(posedge clk); #1 rst_n = 1'b1;

    // 1: clean sweep.
    run_sweep(1'b0);
    check_eq("c1_reads", rd_cnt, 4);
    check_eq("c1_writes", wr_cnt, 0);
    check_eq("c1_corr", corr_a, 0);
    check_eq("c1_uncorr", unc_a, 0);
    check_eq("c1_done", done_cnt, 1);
    check_eq("c1_irq", irq_a, 0);

    // 2: one correctable word at address 2.
    mem[2] = CORR;
    run_sweep(1'b0);
    check_eq("c2_writes", wr_cnt, 1);
    check_eq("c2_wr_addr", wr_addr, 2);
    check_eq("c2_wr_data", wr_data, CLEAN);
    check_eq("c2_corr", corr_a, 1);
    check_eq("c2_uncorr", unc_a, 0);
    check_eq("c2_done", done_cnt, 1);

    // 3: uncorrectable word at address 1.
    mem[1] = BAD;
    run_sweep(1'b0);
    check_eq("c3_reads", rd_cnt, 4);
    check_eq("c3_writes", wr_cnt, 0);
    check_eq("c3_uncorr", unc_a, 1);
    check_eq("c3_last", last_a, 1);
    check_eq("c3_irq", irq_a, 1);
    check_eq("c3_corr", corr_a, 0);
    check_eq("c3_done", done_cnt, 1);

    // 4: grant delayed by 5 cycles; request must hold steady; start clears irq.
    mem[1] = CLEAN;
    gdly = 5;
    run_sweep(1'b0);
    check_eq("c4_reads", rd_cnt, 4);
    check_eq("c4_writes", wr_cnt, 0);
    check_eq("c4_done", done_cnt, 1);
    check_eq("c4_stable", stab_err, 0);
    check_eq("c4_irq", irq_a, 0);
    check_eq("c4_uncorr", unc_a, 0);
    gdly = 0;

    // 5: abort in WT at address 1 with a slow read; stale data must not reach the next sweep.
    rlat = 6;
    mem[1] = BAD;
    sel = 1'b0;
    clear_stats();
    pulse_start();
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk); #1;
      if (m_req && !m_we && m_addr == 8'd1 && gnt) begin
        found = 1'b1;
        break;
      end
    end
    check_eq("c5_reach_addr1", found, 1);
    mem[1] = CLEAN;
    @(posedge clk); #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    @(negedge clk); #1;
    check_eq("c5_idle", busy_a, 0);
    check_eq("c5_no_done", done_cnt, 0);
    run_sweep(1'b0);
    check_eq("c5_reads", rd_cnt, 4);
    check_eq("c5_uncorr", unc_a, 0);
    check_eq("c5_irq", irq_a, 0);
    check_eq("c5_done", done_cnt, 1);
    rlat = 2;
    repeat (10) @(posedge clk);

    // 6: five corrected words on the 2b-counter instance saturate at 3.
    for (int i = 0; i < 8; i++) mem[i] = (i < 5) ? CORR : CLEAN;
    run_sweep(1'b1);
    check_eq("c6_corr_sat", corr_b, 3);
    check_eq("c6_writes", wr_cnt, 5);
    check_eq("c6_reads", rd_cnt, 8);
    check_eq("c6_done", done_cnt, 1);

    // 6b: asynchronous reset while a write request waits for grant.
    mem[0] = CORR;
    gdly = 5;
    clear_stats();
    pulse_start();
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk); #1;
      if (req_b && we_b) begin
        found = 1'b1;
        break;
      end
    end
    check_eq("c6_reach_wr", found, 1);
    rst_n = 1'b0;
    #1;
    check_eq("c6_rst_b", {busy_b, done_b, req_b, we_b, addr_b, wdata_b, dword_b, edata_b,
                          corr_b, unc_b, last_b, irq_b}, '0);
    check_eq("c6_rst_a", {busy_a, req_a, corr_a, unc_a, irq_a}, '0);
    @(posedge clk); #1 rst_n = 1'b1;
    gdly = 0;
    repeat (3) @(negedge clk);
    check_eq("c6_post_idle", busy_b, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
